alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor of the combinational 16-op ALU.
- Registers the operands, then returns a registered result with flags.
- Adds a multi-cycle shift-add multiplier selected by a mode bit.
- Sits between the operand source and the writeback stage; holds at most one operation in flight.

Parameters:
- DATA_WIDTH, 16, operand and result width (>= 4).
- CNT_WIDTH, 5, multiply iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept a request.
- Mode  input  1  0 = FuncCode op, 1 = unsigned multiply (FuncCode ignored).
- FuncCode  input  4  operation select.
- A  input  DATA_WIDTH  operand A.
- B  input  DATA_WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- C  output  DATA_WIDTH  result, low half for multiply.
- CHi  output  DATA_WIDTH  multiply high half; 0 for other ops.
- OverflowFlag  output  1  overflow indication.
- ZeroFlag  output  1  C == 0.
- NegFlag  output  1  C[DATA_WIDTH-1].

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset_n is synchronous and active-low.
  - Reset forces state IDLE, in_ready=1, out_valid=0, and C, CHi, and all flags to 0.
  - Reset mid-multiply abandons the operation; no result is produced.
- FuncCode encoding, single cycle:
  - 0 ADD A+B; 1 SUB A-B.
  - 2 ID A; 3 NOT ~A.
  - 4 AND; 5 OR; 6 NAND; 7 NOR; 8 XOR; 9 XNOR.
  - 10 LLS A<<1; 11 LRS A>>1 (logical).
  - 12 ALS A<<<1 (same bits as LLS); 13 ARS A>>>1 (sign-replicating).
  - 14 TCP ~A+1; 15 ZERO 0.
- OverflowFlag:
  - ADD: set when A and B have the same sign and C's sign differs.
  - SUB: set when A and B have different signs and C's sign differs from A's.
  - All other FuncCode ops: 0. TCP of the most negative value gives OverflowFlag=0 and C unchanged.
  - Multiply: set when CHi != 0.
- States:
  - IDLE: in_ready=1.
    - If in_valid is high with Mode=0, compute and register the result; go to DONE next cycle (latency 1).
    - If in_valid is high with Mode=1, latch A and B, clear the accumulator, set count=0, and go to MUL.
  - MUL: in_ready=0.
    - Each cycle: if multiplier bit[0]=1, add the multiplicand to the upper accumulator half; then shift the {acc, multiplier} register right 1, keeping the carry.
    - After DATA_WIDTH cycles, load {CHi,C} with the 2*DATA_WIDTH product and go to DONE.
    - Latency: DATA_WIDTH+1 cycles from acceptance to out_valid.
  - DONE: out_valid=1, in_ready=0.
    - C, CHi and flags hold stable until out_ready=1.
    - When out_ready is high, go to IDLE next cycle with out_valid=0.
    - No back-to-back bypass: a new request may be accepted one cycle after the handshake.
- Handshakes:
  - Input accepted only on the cycle where in_valid and in_ready are both high.
  - in_valid while busy is ignored; the requester must hold the request.
  - A, B, FuncCode and Mode are sampled only at acceptance; changes afterwards have no effect.
- Flags: ZeroFlag and NegFlag are evaluated on the low half C for all ops, multiply included.
- Arithmetic wraps modulo 2^DATA_WIDTH.
- Multiply is unsigned and exact to 2*DATA_WIDTH bits.

Test Plan:
- Reset and idle: hold reset_n=0 for 2 cycles, then release -> in_ready=1, out_valid=0, C=0, CHi=0, all flags 0.
- Signed add overflow (DATA_WIDTH=16): ADD A=16'h7FFF, B=16'h0001 -> one cycle after accept, out_valid=1, C=16'h8000, OverflowFlag=1, NegFlag=1, ZeroFlag=0.
- Arithmetic shift: ARS A=16'h8004 -> C=16'hC002, OverflowFlag=0.
- Subtract to zero: SUB A=B=16'h1234 -> C=0, ZeroFlag=1.
- Multiply:
  - Mode=1, A=16'hFFFF, B=16'h0003 -> out_valid exactly 17 cycles after accept, C=16'hFFFD, CHi=16'h0002, OverflowFlag=1.
  - A=16'h0010, B=16'h0010 -> C=16'h0100, CHi=0, OverflowFlag=0.
- Backpressure and busy: complete an op, hold out_ready=0 for 5 cycles -> out_valid and C stay stable.
  - in_valid pulsed during MUL and DONE is not accepted.
  - Raise out_ready -> out_valid drops next cycle and in_ready returns to 1.
- Reset mid-multiply: assert reset_n=0 during MUL count 7 -> next cycle IDLE with all outputs 0; the aborted result never appears.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: handshaked registered 16-op ALU with a multi-cycle shift-add unsigned multiplier
module alu_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  Mode,
    input  logic [3:0]            FuncCode,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] C,
    output logic [DATA_WIDTH-1:0] CHi,
    output logic                  OverflowFlag,
    output logic                  ZeroFlag,
    output logic                  NegFlag
);
    localparam int W = DATA_WIDTH;
    localparam logic [W-1:0] ONE = W'(1);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
    state_t state, nextState;
    logic [W-1:0] aluRes, mcand, acc, mplier, nextAcc, nextMplier;
    logic [W:0] mulSum;
    logic [CNT_WIDTH-1:0] cnt;
    logic aluOvf, lastIter;
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    assign lastIter = cnt == CNT_WIDTH'(W - 1);
    assign mulSum = {1'b0, acc} + {1'b0, mplier[0] ? mcand : '0};
    assign nextAcc = mulSum[W:1];
    assign nextMplier = {mulSum[0], mplier[W-1:1]};
    always_comb begin
        aluRes = '0;
        aluOvf = 1'b0;
        case (FuncCode)
            4'd0: begin
                aluRes = A + B;
                aluOvf = (A[W-1] == B[W-1]) && (aluRes[W-1] != A[W-1]);
            end
            4'd1: begin
                aluRes = A - B;
                aluOvf = (A[W-1] != B[W-1]) && (aluRes[W-1] != A[W-1]);
            end
            4'd2: aluRes = A;
            4'd3: aluRes = ~A;
            4'd4: aluRes = A & B;
            4'd5: aluRes = A | B;
            4'd6: aluRes = ~(A & B);
            4'd7: aluRes = ~(A | B);
            4'd8: aluRes = A ^ B;
            4'd9: aluRes = ~(A ^ B);
            4'd10, 4'd12: aluRes = {A[W-2:0], 1'b0};
            4'd11: aluRes = {1'b0, A[W-1:1]};
            4'd13: aluRes = {A[W-1], A[W-1:1]};
            4'd14: aluRes = ~A + ONE;
            default: aluRes = '0;
        endcase
    end
    always_comb begin
        nextState = state;
        case (state)
            IDLE: nextState = in_valid ? (Mode ? MUL : DONE) : IDLE;
            MUL: nextState = lastIter ? DONE : MUL;
            DONE: nextState = out_ready ? IDLE : DONE;
            default: nextState = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            C <= '0;
            CHi <= '0;
            OverflowFlag <= 1'b0;
            ZeroFlag <= 1'b0;
            NegFlag <= 1'b0;
            mcand <= '0;
            acc <= '0;
            mplier <= '0;
            cnt <= '0;
        end else begin
            state <= nextState;
            case (state)
                IDLE: begin
                    if (in_valid && Mode) begin
                        mcand <= A;
                        mplier <= B;
                        acc <= '0;
                        cnt <= '0;
                    end else if (in_valid) begin
                        C <= aluRes;
                        CHi <= '0;
                        OverflowFlag <= aluOvf;
                        ZeroFlag <= aluRes == '0;
                        NegFlag <= aluRes[W-1];
                    end
                end
                MUL: begin
                    acc <= nextAcc;
                    mplier <= nextMplier;
                    cnt <= cnt + CNT_WIDTH'(1);
                    if (lastIter) begin
                        C <= nextMplier;
                        CHi <= nextAcc;
                        OverflowFlag <= nextAcc != '0;
                        ZeroFlag <= nextMplier == '0;
                        NegFlag <= nextMplier[W-1];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven scoreboard bench for alu_seq with handshake, backpressure and abort sequences
module tb_alu_seq;
    typedef struct {
        logic        mode;
        logic [3:0]  fc;
        logic [15:0] a, b, c, chi;
        logic        ov, z, n;
    } vec_t;
    typedef struct packed {
        logic [15:0] c, chi;
        logic        ov, z, n;
    } exp_t;

    logic clk = 0, reset_n = 0, in_valid = 0, Mode = 0, out_ready = 0;
    logic in_ready, out_valid, OverflowFlag, ZeroFlag, NegFlag;
    logic [3:0] FuncCode = 0;
    logic [15:0] A = 0, B = 0, C, CHi;
    int compared = 0, mismatched = 0;
    exp_t sb[$];
    vec_t vecs[23];

    always #5 clk = ~clk;

    alu_seq #(.DATA_WIDTH(16), .CNT_WIDTH(5)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .Mode(Mode), .FuncCode(FuncCode), .A(A), .B(B),
        .out_valid(out_valid), .out_ready(out_ready), .C(C), .CHi(CHi),
        .OverflowFlag(OverflowFlag), .ZeroFlag(ZeroFlag), .NegFlag(NegFlag)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic runOp(input vec_t v, input int hold);
        int lat;
        exp_t e;
        @(negedge clk);
        check("idle in_ready", {31'd0, in_ready}, 1);
        Mode = v.mode; FuncCode = v.fc; A = v.a; B = v.b; in_valid = 1;
        @(posedge clk);
        e.c = v.c; e.chi = v.chi; e.ov = v.ov; e.z = v.z; e.n = v.n;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 0; A = 16'($urandom); B = 16'($urandom);
        FuncCode = 4'($urandom); Mode = ~v.mode;
        lat = 1;
        while (!out_valid && lat < 40) begin
            in_valid = lat[0];
            if (lat == 3) check("busy in_ready", {31'd0, in_ready}, 0);
            @(negedge clk);
            lat++;
        end
        in_valid = 0;
        check("latency", lat, v.mode ? 17 : 1);
        check("done in_ready", {31'd0, in_ready}, 0);
        for (int k = 0; k < hold; k++) begin
            in_valid = k[0];
            @(negedge clk);
            check("hold out_valid", {31'd0, out_valid}, 1);
            check("hold C", {16'd0, C}, {16'd0, v.c});
        end
        in_valid = 0;
        if (sb.size() == 0) begin
            check("scoreboard underflow", 1, 0);
        end else begin
            e = sb.pop_front();
            check("C", {16'd0, C}, {16'd0, e.c});
            check("CHi", {16'd0, CHi}, {16'd0, e.chi});
            check("flags", {29'd0, OverflowFlag, ZeroFlag, NegFlag}, {29'd0, e.ov, e.z, e.n});
        end
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        check("release out_valid", {31'd0, out_valid}, 0);
        check("release in_ready", {31'd0, in_ready}, 1);
    endtask

    initial begin
        vec_t r;
        logic seen;
        vecs[0]  = '{0, 4'd0,  16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 1, 0, 1};
        vecs[1]  = '{0, 4'd13, 16'h8004, 16'h0000, 16'hC002, 16'h0000, 0, 0, 1};
        vecs[2]  = '{0, 4'd1,  16'h1234, 16'h1234, 16'h0000, 16'h0000, 0, 1, 0};
        vecs[3]  = '{0, 4'd1,  16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 1, 0, 0};
        vecs[4]  = '{0, 4'd14, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 0, 0, 1};
        vecs[5]  = '{0, 4'd6,  16'hF0F0, 16'hFF00, 16'h0FFF, 16'h0000, 0, 0, 0};
        vecs[6]  = '{0, 4'd9,  16'hAAAA, 16'h5555, 16'h0000, 16'h0000, 0, 1, 0};
        vecs[7]  = '{0, 4'd10, 16'h8001, 16'h0000, 16'h0002, 16'h0000, 0, 0, 0};
        vecs[8]  = '{0, 4'd11, 16'h8001, 16'h0000, 16'h4000, 16'h0000, 0, 0, 0};
        vecs[9]  = '{0, 4'd7,  16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 0, 0, 1};
        vecs[10] = '{0, 4'd15, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 0, 1, 0};
        vecs[11] = '{0, 4'd0,  16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 0, 1, 0};
        vecs[12] = '{0, 4'd2,  16'h1234, 16'hFFFF, 16'h1234, 16'h0000, 0, 0, 0};
        vecs[13] = '{0, 4'd3,  16'h00FF, 16'h0000, 16'hFF00, 16'h0000, 0, 0, 1};
        vecs[14] = '{0, 4'd8,  16'h0F0F, 16'h00FF, 16'h0FF0, 16'h0000, 0, 0, 0};
        vecs[15] = '{0, 4'd12, 16'h4001, 16'h0000, 16'h8002, 16'h0000, 0, 0, 1};
        vecs[16] = '{0, 4'd4,  16'hF0F0, 16'hFF00, 16'hF000, 16'h0000, 0, 0, 1};
        vecs[17] = '{0, 4'd5,  16'h0F00, 16'h00F0, 16'h0FF0, 16'h0000, 0, 0, 0};
        vecs[18] = '{0, 4'd14, 16'h0001, 16'h0000, 16'hFFFF, 16'h0000, 0, 0, 1};
        vecs[19] = '{1, 4'd0,  16'h0000, 16'h1234, 16'h0000, 16'h0000, 0, 1, 0};
        vecs[20] = '{1, 4'd5,  16'hFFFF, 16'h0003, 16'hFFFD, 16'h0002, 1, 0, 1};
        vecs[21] = '{1, 4'd9,  16'h0010, 16'h0010, 16'h0100, 16'h0000, 0, 0, 0};
        vecs[22] = '{1, 4'd1,  16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1, 0, 0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        check("reset in_ready", {31'd0, in_ready}, 1);
        check("reset out_valid", {31'd0, out_valid}, 0);
        check("reset C", {16'd0, C}, 0);
        check("reset CHi", {16'd0, CHi}, 0);
        check("reset flags", {29'd0, OverflowFlag, ZeroFlag, NegFlag}, 0);

        for (int i = 0; i < 23; i++) runOp(vecs[i], (i == 20) ? 5 : i % 3);

        @(negedge clk);
        Mode = 1; FuncCode = 0; A = 16'hFFFF; B = 16'h0003; in_valid = 1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        repeat (7) @(negedge clk);
        reset_n = 0;
        @(negedge clk);
        reset_n = 1;
        check("abort in_ready", {31'd0, in_ready}, 1);
        check("abort out_valid", {31'd0, out_valid}, 0);
        check("abort C", {16'd0, C}, 0);
        check("abort CHi", {16'd0, CHi}, 0);
        check("abort flags", {29'd0, OverflowFlag, ZeroFlag, NegFlag}, 0);
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("abort no result", {31'd0, seen}, 0);

        r = vecs[20];
        runOp(r, 1);
        runOp(vecs[3], 2);
        check("scoreboard drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
